m_cp0: RTL and testbench

Coprocessor 0 for the pipelined MIPS core, sitting in the M stage as the receiving end of the exception flags raised by the E-stage ALU (arithmetic overflow, address-computation overflow). It merges those flags, earlier-stage exception codes and six hardware interrupt lines into one request, records Cause/EPC/BD, and serves `mfc0`, `mtc0` and `eret`. The `req` output drives pipeline flush and the PC redirect to the handler; `epc_out` drives the PC redirect for `eret`.

---
 rtl/m_cp0.sv | 121 ++++++++++++
 tb/tb_m_cp0.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/m_cp0.sv
// m_cp0: MIPS coprocessor 0 in the M stage.
// Merges upstream exception codes, ALU overflow flags and six hardware
// interrupt lines into a single req, and keeps SR / Cause / EPC / PRId.
// Optional feature macro: CP0_EPC_FWD_EN forwards an in-flight mtc0 EPC
// write straight to epc_out so eret can follow it without a stall.
module m_cp0 #(
  parameter logic [31:0] PRID = 32'h0000_2020
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        we,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  input  logic [31:0] pc,
  input  logic        bd,
  input  logic [4:0]  exc_in,
  input  logic        ari_ov,
  input  logic        dm_ov,
  input  logic        is_load,
  input  logic        is_store,
  input  logic        eret,
  input  logic [5:0]  hw_int,
  output logic [31:0] rdata,
  output logic [31:0] epc_out,
  output logic        req
);

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // SR fields
  logic [5:0]  im;
  logic        exl;
  logic        ie;
  // Cause fields
  logic        bd_q;
  logic [5:0]  ip;
  logic [4:0]  exc_code;
  // EPC
  logic [31:0] epc;

  logic [4:0]  code;
  logic        int_req;
  logic        exc_req;
  logic [31:0] epc_next;

  // Exception code priority: upstream stages first, then ALU overflow, then address faults
  always_comb begin
    code = EXC_NONE;
    if (exc_in != EXC_NONE)   code = exc_in;
    else if (ari_ov)          code = EXC_OV;
    else if (dm_ov && is_load)  code = EXC_ADEL;
    else if (dm_ov && is_store) code = EXC_ADES;
  end

  // Request merge; EXL masks everything, live hw_int feeds the interrupt check
  always_comb begin
    int_req  = ie & ~exl & (|(hw_int & im));
    exc_req  = ~exl & (code != EXC_NONE);
    req      = int_req | exc_req;
    epc_next = bd ? (pc - 32'd4) : pc;
    epc_next[1:0] = 2'b00;
  end

  // State update: req beats eret and mtc0; IP samples the lines every cycle
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      im       <= '0;
      exl      <= 1'b0;
      ie       <= 1'b0;
      bd_q     <= 1'b0;
      ip       <= '0;
      exc_code <= '0;
      epc      <= '0;
    end else begin
      ip <= hw_int;
      if (req) begin
        exl      <= 1'b1;
        exc_code <= int_req ? EXC_NONE : code;
        bd_q     <= bd;
        epc      <= epc_next;
      end else begin
        if (eret) exl <= 1'b0;
        if (we) begin
          if (addr == 5'd12) begin
            im  <= wdata[15:10];
            exl <= wdata[1];
            ie  <= wdata[0];
          end
          if (addr == 5'd14) epc <= {wdata[31:2], 2'b00};
        end
      end
    end
  end

  // mfc0 read mux; unimplemented registers read zero
  always_comb begin
    case (addr)
      5'd12:   rdata = {16'b0, im, 8'b0, exl, ie};
      5'd13:   rdata = {bd_q, 15'b0, ip, 3'b0, exc_code, 2'b0};
      5'd14:   rdata = epc;
      5'd15:   rdata = PRID;
      default: rdata = 32'b0;
    endcase
  end

`ifdef CP0_EPC_FWD_EN
  // Bypass a same-cycle mtc0 EPC so a back-to-back eret sees the new target
  always_comb begin
    epc_out = ((we == 1'b1) && (addr == 5'd14)) ? {wdata[31:2], 2'b00} : epc;
  end
`else
  // Registered EPC only; eret must trail an EPC write by one cycle
  always_comb begin
    epc_out = epc;
  end
`endif

endmodule

// File: tb/tb_m_cp0.sv
// Self-checking bench for m_cp0: directed scenarios plus a randomized run
// checked against a register-level reference model.
module tb_m_cp0;

  localparam logic [31:0] PRID = 32'h0000_2020;

  logic        clk = 1'b0;
  logic        reset;
  logic        we;
  logic [4:0]  addr;
  logic [31:0] wdata;
  logic [31:0] pc;
  logic        bd;
  logic [4:0]  exc_in;
  logic        ari_ov;
  logic        dm_ov;
  logic        is_load;
  logic        is_store;
  logic        eret;
  logic [5:0]  hw_int;
  logic [31:0] rdata;
  logic [31:0] epc_out;
  logic        req;

  int n_pass = 0;
  int n_total = 0;

  // reference model: whole architectural registers as 32-bit words
  logic [31:0] m_sr, m_cause, m_epc;

  m_cp0 #(.PRID(PRID)) dut (
    .clk(clk), .reset(reset), .we(we), .addr(addr), .wdata(wdata),
    .pc(pc), .bd(bd), .exc_in(exc_in), .ari_ov(ari_ov), .dm_ov(dm_ov),
    .is_load(is_load), .is_store(is_store), .eret(eret), .hw_int(hw_int),
    .rdata(rdata), .epc_out(epc_out), .req(req)
  );

  always #5 clk = ~clk;

  function automatic logic [4:0] m_code();
    if (exc_in != 0) return exc_in;
    if (ari_ov) return 5'd12;
    if (dm_ov && is_load) return 5'd4;
    if (dm_ov && is_store) return 5'd5;
    return 5'd0;
  endfunction

  function automatic logic m_int();
    return m_sr[0] && !m_sr[1] && ((hw_int & m_sr[15:10]) != 0);
  endfunction

  function automatic logic m_req();
    return m_int() || (!m_sr[1] && m_code() != 0);
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    case (a)
      12: return m_sr;
      13: return m_cause;
      14: return m_epc;
      15: return PRID;
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] m_epc_out();
`ifdef CP0_EPC_FWD_EN
    if (we && addr == 14) return wdata & 32'hFFFF_FFFC;
`endif
    return m_epc;
  endfunction

  // advance the model by one clock using current inputs, then clock the DUT
  task automatic tick();
    logic r, i;
    logic [4:0] c;
    logic [31:0] t;
    r = m_req(); i = m_int(); c = m_code();
    m_cause[15:10] = hw_int;
    if (r) begin
      m_sr[1] = 1'b1;
      m_cause[6:2] = i ? 5'd0 : c;
      m_cause[31] = bd;
      t = bd ? pc - 32'd4 : pc;
      m_epc = t & 32'hFFFF_FFFC;
    end else begin
      if (eret) m_sr[1] = 1'b0;
      if (we && addr == 12) m_sr = wdata & 32'h0000_FC03;
      if (we && addr == 14) m_epc = wdata & 32'hFFFF_FFFC;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    we = 0; addr = 0; wdata = 0; pc = 0; bd = 0; exc_in = 0; ari_ov = 0;
    dm_ov = 0; is_load = 0; is_store = 0; eret = 0; hw_int = 0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    @(posedge clk); #1;
    reset = 1;
    #1;
  endtask

  task automatic test_reset();
    logic [4:0] al [4] = '{5'd15, 5'd12, 5'd13, 5'd14};
    logic [31:0] el [4] = '{PRID, 32'd0, 32'd0, 32'd0};
    idle_inputs();
    reset = 0;
    m_sr = 0; m_cause = 0; m_epc = 0;
    #3;
    for (int k = 0; k < 4; k++) begin
      addr = al[k]; #1;
      n_total++;
      if (rdata !== el[k]) $display("FAIL reset_rdata addr=%0d got=%h exp=%h", addr, rdata, el[k]);
      else n_pass++;
    end
    n_total++;
    if (req !== 1'b0 || epc_out !== 32'd0) $display("FAIL reset_req req=%b epc_out=%h exp 0/0", req, epc_out);
    else n_pass++;
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    addr = 12; #1;
    n_total++;
    if (rdata !== 32'd0 || req !== 1'b0) $display("FAIL reset_release sr=%h req=%b exp 0/0", rdata, req);
    else n_pass++;
  endtask

  task automatic test_ov();
    do_reset();
    ari_ov = 1; pc = 32'h0000_3010; bd = 0; #1;
    n_total++;
    if (req !== 1'b1) $display("FAIL ov_req got=%b exp=1", req); else n_pass++;
    tick();
    idle_inputs(); addr = 13; #1;
    n_total++;
    if (rdata !== 32'h0000_0030) $display("FAIL ov_cause got=%h exp=00000030", rdata); else n_pass++;
    addr = 14; #1;
    n_total++;
    if (rdata !== 32'h0000_3010) $display("FAIL ov_epc got=%h exp=00003010", rdata); else n_pass++;
    addr = 12; #1;
    n_total++;
    if (rdata !== 32'h0000_0002) $display("FAIL ov_sr got=%h exp=00000002", rdata); else n_pass++;
  endtask

  task automatic test_addr_err();
    for (int k = 0; k < 2; k++) begin
      do_reset();
      dm_ov = 1; is_store = (k == 0); is_load = (k == 1); bd = 1; pc = 32'h0000_3008;
      tick();
      idle_inputs(); addr = 13; #1;
      n_total++;
      if (rdata !== (k == 0 ? 32'h8000_0014 : 32'h8000_0010))
        $display("FAIL addr_err_cause k=%0d got=%h exp=%h", k, rdata, (k == 0 ? 32'h8000_0014 : 32'h8000_0010));
      else n_pass++;
      addr = 14; #1;
      n_total++;
      if (rdata !== 32'h0000_3004) $display("FAIL addr_err_epc got=%h exp=00003004", rdata); else n_pass++;
    end
  endtask

  // interrupt entry, masking under EXL, then eret re-opening the pending interrupt
  task automatic test_int_eret();
    do_reset();
    we = 1; addr = 12; wdata = 32'h0000_0401;
    tick();
    we = 0; hw_int = 6'd1; pc = 32'h0000_5000; #1;
    n_total++;
    if (req !== 1'b1) $display("FAIL int_req got=%b exp=1", req); else n_pass++;
    tick();
    addr = 13; #1;
    n_total++;
    if (rdata !== 32'h0000_0400) $display("FAIL int_cause got=%h exp=00000400", rdata); else n_pass++;
    addr = 12; #1;
    n_total++;
    if (rdata !== 32'h0000_0403) $display("FAIL int_sr got=%h exp=00000403", rdata); else n_pass++;
    ari_ov = 1; #1;
    n_total++;
    if (req !== 1'b0) $display("FAIL exl_mask got=%b exp=0", req); else n_pass++;
    ari_ov = 0; eret = 1; exc_in = 5'd10; #1;
    n_total++;
    if (req !== 1'b0) $display("FAIL eret_mask got=%b exp=0", req); else n_pass++;
    tick();
    eret = 0; exc_in = 0; #1;
    n_total++;
    if (rdata[1] !== 1'b0 || req !== 1'b1) $display("FAIL eret_exit exl=%b req=%b exp 0/1", rdata[1], req);
    else n_pass++;
    do_reset();
    eret = 1; ari_ov = 1; #1;
    n_total++;
    if (req !== 1'b1) $display("FAIL eret_vs_req got=%b exp=1", req); else n_pass++;
    tick();
    idle_inputs(); addr = 12; #1;
    n_total++;
    if (rdata[1] !== 1'b1) $display("FAIL eret_vs_exl got=%b exp=1", rdata[1]); else n_pass++;
  endtask

  task automatic test_epc_fwd();
    logic [31:0] exp_now;
`ifdef CP0_EPC_FWD_EN
    exp_now = 32'h0000_4000;
`else
    exp_now = 32'h0000_0000;
`endif
    do_reset();
    we = 1; addr = 14; wdata = 32'h0000_4003; #1;
    n_total++;
    if (epc_out !== exp_now) $display("FAIL epc_fwd_now got=%h exp=%h", epc_out, exp_now); else n_pass++;
    tick();
    we = 0; #1;
    n_total++;
    if (epc_out !== 32'h0000_4000) $display("FAIL epc_next got=%h exp=00004000", epc_out); else n_pass++;
    we = 1; addr = 13; wdata = 32'hFFFF_FFFF;
    tick();
    we = 0; #1;
    n_total++;
    if (rdata !== 32'h0000_0000) $display("FAIL cause_ro got=%h exp=00000000", rdata); else n_pass++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    exc_in = 5'd8; pc = 32'h0000_7000;
    tick();
    idle_inputs(); addr = 12;
    #2 reset = 0; #1;
    n_total++;
    if (rdata !== 32'd0 || epc_out !== 32'd0) $display("FAIL mid_reset sr=%h epc=%h exp 0/0", rdata, epc_out);
    else n_pass++;
    m_sr = 0; m_cause = 0; m_epc = 0;
    @(posedge clk); #1;
    reset = 1; #1;
  endtask

  task automatic test_random();
    logic [4:0] ra [5] = '{5'd12, 5'd13, 5'd14, 5'd15, 5'd3};
    int errs;
    errs = 0;
    do_reset();
    for (int n = 0; n < 400; n++) begin
      exc_in  = ($urandom_range(0, 9) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      ari_ov  = ($urandom_range(0, 7) == 0);
      dm_ov   = ($urandom_range(0, 7) == 0);
      is_load = $urandom_range(0, 1);
      is_store = !is_load && ($urandom_range(0, 1) == 1);
      bd      = $urandom_range(0, 1);
      pc      = $urandom;
      hw_int  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      eret    = ($urandom_range(0, 3) == 0);
      we      = !eret && ($urandom_range(0, 2) == 0);
      addr    = ra[$urandom_range(0, 4)];
      wdata   = $urandom;
      #1;
      n_total++;
      if (req !== m_req() || rdata !== m_read(addr) || epc_out !== m_epc_out()) begin
        errs++;
        if (errs < 10)
          $display("FAIL rand cyc=%0d req=%b/%b rdata=%h/%h epc_out=%h/%h", n,
                   req, m_req(), rdata, m_read(addr), epc_out, m_epc_out());
      end else n_pass++;
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_ov();
    test_addr_err();
    test_int_eret();
    test_epc_fwd();
    test_mid_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
